y86_seq_ctrl: RTL and testbench

Multicycle sequencer for the sequential Y86-64 datapath. Each instruction is stepped through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPDATE, with one enable strobe per stage. The block owns the architectural PC and selects next-PC from valP, valC or valM. It handshakes with data memory, tracks processor status (AOK/HLT/ADR/INS) and counts retired instructions.

---
 rtl/y86_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_y86_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : y86_seq_ctrl
// Brief    : Multicycle sequencer for the sequential Y86-64 datapath. Owns the
//            architectural PC, the status code and the retired counter.
// Revision : 1.0 - initial release
// ============================================================================
module y86_seq_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          IMEM_LAST   = 1023,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic        instr_val,
    input  logic        imem_er,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    input  logic        mem_ready,
    input  logic        dmem_er,
    output logic [63:0] pc,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_req,
    output logic        wb_en,
    output logic [2:0]  stat,
    output logic        busy,
    output logic [31:0] retired
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_mem    = 3'd4;
    localparam logic [2:0] c_st_wb     = 3'd5;
    localparam logic [2:0] c_st_pcupd  = 3'd6;
    localparam logic [2:0] c_st_stop   = 3'd7;

    localparam logic [2:0] c_stat_aok = 3'd1;
    localparam logic [2:0] c_stat_hlt = 3'd2;
    localparam logic [2:0] c_stat_adr = 3'd3;
    localparam logic [2:0] c_stat_ins = 3'd4;

    localparam logic [63:0] c_imem_last = 64'(IMEM_LAST);
    localparam logic [31:0] c_tmo_last  = 32'(MEM_TIMEOUT - 1);

    logic [2:0]  r_state, w_state_nx;
    logic [63:0] r_pc, w_pc_nx;
    logic [2:0]  r_stat, w_stat_nx;
    logic [31:0] r_retired, w_retired_nx;
    logic [31:0] r_tmo, w_tmo_nx;
    logic [63:0] r_valm, w_valm_nx;
    logic [3:0]  r_icode, w_icode_nx;
    logic        w_needs_mem;

    // ifun is reserved for future status checks
    logic w_unused_ifun;
    assign w_unused_ifun = ^ifun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_pc      <= RESET_PC;
            r_stat    <= c_stat_aok;
            r_retired <= 32'd0;
            r_tmo     <= 32'd0;
            r_valm    <= 64'd0;
            r_icode   <= 4'd0;
        end else begin
            r_state   <= w_state_nx;
            r_pc      <= w_pc_nx;
            r_stat    <= w_stat_nx;
            r_retired <= w_retired_nx;
            r_tmo     <= w_tmo_nx;
            r_valm    <= w_valm_nx;
            r_icode   <= w_icode_nx;
        end
    end

    // Memory-touching opcodes: rmmovq, mrmovq, call, ret, pushq, popq
    assign w_needs_mem = (r_icode == 4'h4) || (r_icode == 4'h5) || (r_icode == 4'h8) ||
                         (r_icode == 4'h9) || (r_icode == 4'hA) || (r_icode == 4'hB);

    always_comb begin
        w_state_nx   = r_state;
        w_pc_nx      = r_pc;
        w_stat_nx    = r_stat;
        w_retired_nx = r_retired;
        w_tmo_nx     = r_tmo;
        w_valm_nx    = r_valm;
        w_icode_nx   = r_icode;
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        exec_en      = 1'b0;
        mem_req      = 1'b0;
        wb_en        = 1'b0;
        busy         = (r_state != c_st_idle) && (r_state != c_st_stop);
        case (r_state)
            c_st_idle: begin
                if (run) w_state_nx = c_st_fetch;
            end
            c_st_fetch: begin
                if (run) begin
                    fetch_en = 1'b1;
                    if (r_pc > c_imem_last) begin
                        w_stat_nx  = c_stat_adr;
                        w_state_nx = c_st_stop;
                    end else begin
                        w_state_nx = c_st_decode;
                    end
                end
            end
            c_st_decode: begin
                if (run) begin
                    decode_en = 1'b1;
                    if (imem_er) begin
                        w_stat_nx  = c_stat_adr;
                        w_state_nx = c_st_stop;
                    end else if (!instr_val || (icode > 4'hB)) begin
                        w_stat_nx  = c_stat_ins;
                        w_state_nx = c_st_stop;
                    end else if (icode == 4'h0) begin
                        w_stat_nx  = c_stat_hlt;
                        w_state_nx = c_st_stop;
                    end else begin
                        w_icode_nx = icode;
                        w_state_nx = c_st_exec;
                    end
                end
            end
            c_st_exec: begin
                if (run) begin
                    exec_en    = 1'b1;
                    w_state_nx = w_needs_mem ? c_st_mem : c_st_wb;
                end
            end
            c_st_mem: begin
                // request stays up while frozen so the memory side never sees it drop
                mem_req = 1'b1;
                if (run) begin
                    if (mem_ready) begin
                        w_tmo_nx = 32'd0;
                        if (dmem_er) begin
                            w_stat_nx  = c_stat_adr;
                            w_state_nx = c_st_stop;
                        end else begin
                            w_valm_nx  = valM;
                            w_state_nx = c_st_wb;
                        end
                    end else if (r_tmo >= c_tmo_last) begin
                        w_tmo_nx   = 32'd0;
                        w_stat_nx  = c_stat_adr;
                        w_state_nx = c_st_stop;
                    end else begin
                        w_tmo_nx = r_tmo + 32'd1;
                    end
                end
            end
            c_st_wb: begin
                if (run) begin
                    wb_en      = 1'b1;
                    w_state_nx = c_st_pcupd;
                end
            end
            c_st_pcupd: begin
                if ((r_icode == 4'h8) || ((r_icode == 4'h7) && cnd)) w_pc_nx = valC;
                else if (r_icode == 4'h9)                            w_pc_nx = r_valm;
                else                                                 w_pc_nx = valP;
                w_retired_nx = r_retired + 32'd1;
                w_state_nx   = run ? c_st_fetch : c_st_idle;
            end
            c_st_stop: begin
            end
            default: w_state_nx = c_st_idle;
        endcase
    end

    assign pc      = r_pc;
    assign stat    = r_stat;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_y86_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_y86_seq_ctrl
// Brief    : Directed self-checking bench for the Y86-64 sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_y86_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, instr_val, imem_er, cnd, mem_ready, dmem_er;
    logic [3:0]  icode, ifun;
    logic [63:0] valC, valP, valM;
    logic [63:0] pc;
    logic        fetch_en, decode_en, exec_en, mem_req, wb_en, busy;
    logic [2:0]  stat;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    y86_seq_ctrl #(.RESET_PC(64'd0), .IMEM_LAST(1023), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .run(run), .icode(icode), .ifun(ifun),
        .instr_val(instr_val), .imem_er(imem_er), .cnd(cnd), .valC(valC),
        .valP(valP), .valM(valM), .mem_ready(mem_ready), .dmem_er(dmem_er),
        .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .mem_req(mem_req), .wb_en(wb_en), .stat(stat), .busy(busy), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; run = 1'b0; icode = 4'h0; ifun = 4'h0; instr_val = 1'b1;
        imem_er = 1'b0; cnd = 1'b0; valC = 64'd0; valP = 64'd0; valM = 64'd0;
        mem_ready = 1'b0; dmem_er = 1'b0;
        #3;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (pc !== 64'd0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc); end
        checks++; if (stat !== 3'd1) begin errors++; $display("FAIL reset_stat: got %0d expected 1", stat); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        checks++; if ({busy, fetch_en, decode_en, exec_en, wb_en, mem_req} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 000000", {busy, fetch_en, decode_en, exec_en, wb_en, mem_req}); end
    endtask

    task automatic test_simple;
        icode = 4'h3; valP = 64'd10; run = 1'b1;
        step();
        checks++; if ({fetch_en, decode_en, exec_en, wb_en, mem_req} !== 5'b10000 || busy !== 1'b1) begin
            errors++; $display("FAIL simple_fetch: got %b expected 10000", {fetch_en, decode_en, exec_en, wb_en, mem_req}); end
        step();
        checks++; if ({fetch_en, decode_en, exec_en, wb_en, mem_req} !== 5'b01000) begin
            errors++; $display("FAIL simple_decode: got %b expected 01000", {fetch_en, decode_en, exec_en, wb_en, mem_req}); end
        step();
        checks++; if ({fetch_en, decode_en, exec_en, wb_en, mem_req} !== 5'b00100) begin
            errors++; $display("FAIL simple_exec: got %b expected 00100", {fetch_en, decode_en, exec_en, wb_en, mem_req}); end
        step();
        checks++; if ({fetch_en, decode_en, exec_en, wb_en, mem_req} !== 5'b00010) begin
            errors++; $display("FAIL simple_wb: got %b expected 00010", {fetch_en, decode_en, exec_en, wb_en, mem_req}); end
        step();
        checks++; if ({fetch_en, decode_en, exec_en, wb_en, mem_req} !== 5'b00000 || pc !== 64'd0) begin
            errors++; $display("FAIL simple_pcupd: strobes %b pc %0h expected 00000 pc 0", {fetch_en, decode_en, exec_en, wb_en, mem_req}, pc); end
        step();
        checks++; if (pc !== 64'd10) begin errors++; $display("FAIL simple_pc: got %0h expected a", pc); end
        checks++; if (retired !== 32'd1 || stat !== 3'd1 || fetch_en !== 1'b1) begin
            errors++; $display("FAIL simple_retire: retired %0d stat %0d fetch_en %b expected 1 1 1", retired, stat, fetch_en); end
    endtask

    task automatic test_jxx;
        int memseen;
        memseen = 0;
        icode = 4'h7; valC = 64'h40; valP = 64'h20; cnd = 1'b1;
        repeat (5) begin step(); if (mem_req) memseen++; end
        checks++; if (pc !== 64'h40 || memseen != 0) begin
            errors++; $display("FAIL jxx_taken: pc %0h mem cycles %0d expected 40 0", pc, memseen); end
        cnd = 1'b0; valP = 64'd9;
        repeat (5) begin step(); if (mem_req) memseen++; end
        checks++; if (pc !== 64'd9 || memseen != 0) begin
            errors++; $display("FAIL jxx_not_taken: pc %0h mem cycles %0d expected 9 0", pc, memseen); end
        checks++; if (retired !== 32'd3) begin errors++; $display("FAIL jxx_retired: got %0d expected 3", retired); end
    endtask

    task automatic test_mem_wait;
        int n;
        icode = 4'h9; valM = 64'h2A; valP = 64'h77; mem_ready = 1'b0;
        step(); step(); step();
        n = 0;
        while (mem_req === 1'b1 && n < 20) begin
            n++;
            mem_ready = (n == 4);
            step();
        end
        mem_ready = 1'b0;
        checks++; if (n != 4) begin errors++; $display("FAIL ret_mem_req_cycles: got %0d expected 4", n); end
        checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL ret_wb: got %b expected 1", wb_en); end
        step(); step();
        checks++; if (pc !== 64'h2A || retired !== 32'd4) begin
            errors++; $display("FAIL ret_pc: pc %0h retired %0d expected 2a 4", pc, retired); end
    endtask

    task automatic test_timeout;
        int n;
        icode = 4'h5; mem_ready = 1'b0;
        step(); step(); step();
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin n++; step(); end
        checks++; if (n != 16) begin errors++; $display("FAIL timeout_cycles: got %0d expected 16", n); end
        checks++; if (stat !== 3'd3 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_stat: stat %0d busy %b expected 3 0", stat, busy); end
        repeat (3) step();
        checks++; if (pc !== 64'h2A || stat !== 3'd3 || retired !== 32'd4 || fetch_en !== 1'b0) begin
            errors++; $display("FAIL stop_frozen: pc %0h stat %0d retired %0d fetch_en %b expected 2a 3 4 0", pc, stat, retired, fetch_en); end
    endtask

    task automatic test_halt;
        do_reset();
        run = 1'b1; icode = 4'h3; valP = 64'h35;
        repeat (6) step();
        icode = 4'h0;
        step(); step();
        checks++; if (stat !== 3'd2 || busy !== 1'b0) begin
            errors++; $display("FAIL halt_stat: stat %0d busy %b expected 2 0", stat, busy); end
        repeat (2) step();
        checks++; if (pc !== 64'h35 || retired !== 32'd1) begin
            errors++; $display("FAIL halt_pc: pc %0h retired %0d expected 35 1", pc, retired); end
    endtask

    task automatic test_illegal;
        do_reset();
        run = 1'b1; icode = 4'hC;
        step(); step(); step();
        checks++; if (stat !== 3'd4) begin errors++; $display("FAIL ins_icode_c: got %0d expected 4", stat); end
        do_reset();
        run = 1'b1; icode = 4'h3; instr_val = 1'b0;
        step(); step(); step();
        checks++; if (stat !== 3'd4) begin errors++; $display("FAIL ins_not_valid: got %0d expected 4", stat); end
        do_reset();
        run = 1'b1; icode = 4'hC; imem_er = 1'b1;
        step(); step(); step();
        checks++; if (stat !== 3'd3 || retired !== 32'd0) begin
            errors++; $display("FAIL imem_er_priority: stat %0d retired %0d expected 3 0", stat, retired); end
    endtask

    task automatic test_pc_bound;
        do_reset();
        run = 1'b1; icode = 4'h3; valP = 64'd1023;
        repeat (6) step();
        step();
        checks++; if (pc !== 64'd1023 || decode_en !== 1'b1) begin
            errors++; $display("FAIL pc_last_ok: pc %0d decode_en %b expected 1023 1", pc, decode_en); end
        valP = 64'd1024;
        repeat (4) step();
        checks++; if (pc !== 64'd1024 || fetch_en !== 1'b1) begin
            errors++; $display("FAIL pc_over_fetch: pc %0d fetch_en %b expected 1024 1", pc, fetch_en); end
        step();
        checks++; if (stat !== 3'd3 || busy !== 1'b0) begin
            errors++; $display("FAIL pc_over_stat: stat %0d busy %b expected 3 0", stat, busy); end
    endtask

    task automatic test_freeze_and_async_reset;
        do_reset();
        run = 1'b1; icode = 4'h3; valP = 64'h50;
        step(); step();
        run = 1'b0;
        #1;
        checks++; if (decode_en !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL freeze_strobe: decode_en %b busy %b expected 0 1", decode_en, busy); end
        step(); step();
        run = 1'b1;
        #1;
        checks++; if (decode_en !== 1'b1) begin errors++; $display("FAIL freeze_resume: got %b expected 1", decode_en); end
        repeat (5) step();
        checks++; if (pc !== 64'h50 || retired !== 32'd1) begin
            errors++; $display("FAIL freeze_pc: pc %0h retired %0d expected 50 1", pc, retired); end
        icode = 4'h4;
        step(); step(); step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmmov_mem_req: got %b expected 1", mem_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || pc !== 64'd0 || stat !== 3'd1 || busy !== 1'b0 || retired !== 32'd0) begin
            errors++; $display("FAIL async_reset: mem_req %b pc %0h stat %0d busy %b retired %0d expected 0 0 1 0 0",
                               mem_req, pc, stat, busy, retired); end
        #3 rst = 1'b0;
        step();
        checks++; if (fetch_en !== 1'b1 || pc !== 64'd0) begin
            errors++; $display("FAIL restart_after_reset: fetch_en %b pc %0h expected 1 0", fetch_en, pc); end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_jxx();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_illegal();
        test_pc_bound();
        test_freeze_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
